// File: rtl/biu_slave.sv
// biu_slave: shared-bus slave that decodes one address window, bridges
// requests onto a simple local register port and answers reads on the bus.
// A read watchdog guarantees every decoded read receives a bus response.
module biu_slave #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 'h0000_1000,
    parameter int                    ADDR_SPAN      = 'h100,
    parameter int                    TIMEOUT_CYCLES = 16,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA       = 'hDEAD_BEEF,
    parameter int                    OFFSET_WIDTH   = $clog2(ADDR_SPAN)
) (
    input  logic                    clk,
    input  logic                    n_rst,
    inout  wire  [ADDR_WIDTH-1:0]   bus_address,
    inout  wire  [DATA_WIDTH-1:0]   bus_data,
    inout  wire  [1:0]              bus_control,
    output logic [OFFSET_WIDTH-1:0] o_address,
    output logic [DATA_WIDTH-1:0]   o_wr_data,
    output logic                    o_wr_en,
    output logic                    o_rd_en,
    input  logic [DATA_WIDTH-1:0]   i_rd_data,
    input  logic                    i_rd_valid,
    output logic                    o_timeout,
    output logic                    o_busy
);

    // Upper address bits that must match BASE_ADDR for a request to be ours.
    localparam logic [ADDR_WIDTH-1:0] WIN_MASK = ~ADDR_WIDTH'(ADDR_SPAN - 1);
    // Counter value seen in the last READ cycle before the watchdog fires.
    localparam logic [7:0]            LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        WRITE = 4'b0010,
        READ  = 4'b0100,
        RESP  = 4'b1000
    } state_t;

    state_t                  state_q, state_d;
    logic [OFFSET_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    timeout_q, timeout_d;

    logic hit;
    logic rnw;
    logic expired;
    logic drive;

    assign hit     = bus_control[0] && ((bus_address & WIN_MASK) == BASE_ADDR);
    assign rnw     = bus_control[1];
    assign expired = (cnt_q == LAST_CNT);

    // State and datapath registers; async reset aborts any transaction.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state: requests are only decoded while idle; reads leave on data or expiry.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (hit) state_d = rnw ? READ : WRITE;
            WRITE:   state_d = IDLE;
            READ:    if (i_rd_valid || expired) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: request capture, watchdog count and read data capture.
    always_comb begin
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        cnt_d     = 8'd0;
        timeout_d = 1'b0;
        if (state_q == IDLE && hit) begin
            addr_d  = bus_address[OFFSET_WIDTH-1:0];
            wdata_d = bus_data;
        end
        if (state_q == READ) begin
            cnt_d = cnt_q + 8'd1;
            // Real data wins when it arrives in the same cycle the watchdog expires.
            if (i_rd_valid) begin
                rdata_d = i_rd_data;
            end else if (expired) begin
                rdata_d   = ERR_DATA;
                timeout_d = 1'b1;
            end
        end
    end

    // Outputs decoded from the registered state so reset takes effect immediately.
    always_comb begin
        drive     = (state_q == RESP);
        o_wr_en   = (state_q == WRITE);
        o_rd_en   = (state_q == READ);
        o_busy    = (state_q != IDLE);
        o_timeout = timeout_q;
        o_address = addr_q;
        o_wr_data = wdata_q;
    end

    // The bus belongs to the master except during the single response cycle;
    // the echoed address lies in our own window so no other slave decodes it.
    assign bus_address = drive ? (BASE_ADDR | ADDR_WIDTH'(addr_q)) : 'z;
    assign bus_data    = drive ? rdata_q : 'z;
    assign bus_control = drive ? 2'b11 : 2'bzz;

endmodule

// File: tb/tb_biu_slave.sv
// tb_biu_slave: randomized bus-master stimulus for biu_slave, checked every
// cycle against a transaction-level expectation queue, plus literal checks.
module tb_biu_slave;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          SPAN = 256;
    localparam int          TMO  = 16;
    localparam logic [31:0] ERR  = 32'hDEAD_BEEF;
    localparam int          LOGN = 8192;

    logic        clk;
    logic        n_rst;
    logic [31:0] m_addr, m_data;
    logic [1:0]  m_ctrl;
    logic        m_drv;
    logic [31:0] i_rd_data;
    logic        i_rd_valid;

    wire  [31:0] bus_address;
    wire  [31:0] bus_data;
    wire  [1:0]  bus_control;
    logic [7:0]  o_address;
    logic [31:0] o_wr_data;
    logic        o_wr_en, o_rd_en, o_timeout, o_busy;

    assign bus_address = m_drv ? m_addr : 'z;
    assign bus_data    = m_drv ? m_data : 'z;
    assign bus_control = m_drv ? m_ctrl : 2'bzz;

    biu_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(BASE), .ADDR_SPAN(SPAN),
        .TIMEOUT_CYCLES(TMO), .ERR_DATA(ERR)
    ) dut (
        .clk(clk), .n_rst(n_rst),
        .bus_address(bus_address), .bus_data(bus_data), .bus_control(bus_control),
        .o_address(o_address), .o_wr_data(o_wr_data), .o_wr_en(o_wr_en),
        .o_rd_en(o_rd_en), .i_rd_data(i_rd_data), .i_rd_valid(i_rd_valid),
        .o_timeout(o_timeout), .o_busy(o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected per-cycle behaviour; an empty queue means "idle".
    typedef struct {
        bit          wr_en;
        bit          rd_en;
        bit          busy;
        bit          tmo;
        bit          resp;
        logic [7:0]  off;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  m_off;
    logic [31:0] m_wdata;
    int          cyc;
    int          n_cmp;
    int          n_bad;

    logic [1:0]  log_ctrl  [0:LOGN-1];
    logic [31:0] log_bdata [0:LOGN-1];
    logic [31:0] log_baddr [0:LOGN-1];
    logic [7:0]  log_addr  [0:LOGN-1];
    logic [31:0] log_wdata [0:LOGN-1];
    logic        log_wr_en [0:LOGN-1];
    logic        log_rd_en [0:LOGN-1];
    logic        log_busy  [0:LOGN-1];
    logic        log_tmo   [0:LOGN-1];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h, want %h", nm, cyc, act, exp);
        end
    endtask

    function automatic bit is_hit(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + SPAN);
    endfunction

    function automatic logic [31:0] miss_addr();
        logic [31:0] a;
        a = $urandom;
        if (is_hit(a)) a = a ^ 32'h8000_0000;
        return a;
    endfunction

    function automatic exp_t idle_exp();
        exp_t e;
        e.wr_en = 0; e.rd_en = 0; e.busy = 0; e.tmo = 0; e.resp = 0;
        e.off = m_off; e.wdata = m_wdata; e.rdata = '0;
        return e;
    endfunction

    // Compare process: one check set per cycle, sampled 1 time unit after posedge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc++;
        if (cyc < LOGN) begin
            log_ctrl[cyc]  = bus_control;  log_bdata[cyc] = bus_data;
            log_baddr[cyc] = bus_address;  log_addr[cyc]  = o_address;
            log_wdata[cyc] = o_wr_data;    log_wr_en[cyc] = o_wr_en;
            log_rd_en[cyc] = o_rd_en;      log_busy[cyc]  = o_busy;
            log_tmo[cyc]   = o_timeout;
        end
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = idle_exp();
        chk("o_wr_en", o_wr_en, e.wr_en);
        chk("o_rd_en", o_rd_en, e.rd_en);
        chk("o_busy", o_busy, e.busy);
        chk("o_timeout", o_timeout, e.tmo);
        chk("o_address", o_address, e.off);
        chk("o_wr_data", o_wr_data, e.wdata);
        if (e.resp) begin
            chk("resp_ctrl", bus_control, 2'b11);
            chk("resp_data", bus_data, e.rdata);
            chk("resp_addr", bus_address, BASE + 32'(e.off));
        end else if (!m_drv) begin
            chk("bus_released", bus_control[0] === 1'b1, 1'b0);
        end
    end

    task automatic noise();
        int r;
        r = $urandom_range(0, 3);
        i_rd_valid = 1'($urandom_range(0, 1));
        i_rd_data  = $urandom;
        if (r == 1) begin
            m_addr = miss_addr(); m_data = $urandom;
            m_ctrl = {1'($urandom_range(0, 1)), 1'b1}; m_drv = 1;
        end else if (r == 2) begin
            m_addr = BASE + $urandom_range(0, SPAN - 1); m_data = $urandom;
            m_ctrl = {1'($urandom_range(0, 1)), 1'b0}; m_drv = 1;
        end else begin
            m_drv = 0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            noise();
        end
    endtask

    // One master transaction; k = READ cycle carrying i_rd_valid (0 = never).
    task automatic do_txn(input logic [31:0] addr, input logic [31:0] data, input bit rnw,
                          input int k, input logic [31:0] rdat, input bit rst3,
                          output int reqc);
        int   rr;
        bit   hit;
        exp_t e;
        @(negedge clk);
        reqc   = cyc;
        m_addr = addr; m_data = data; m_ctrl = {rnw, 1'b1}; m_drv = 1;
        i_rd_valid = 1'($urandom_range(0, 1));
        i_rd_data  = $urandom;
        hit = is_hit(addr);
        rr  = 0;
        if (hit) begin
            m_off   = 8'(addr - BASE);
            m_wdata = data;
            e = idle_exp();
            if (!rnw) begin
                e.wr_en = 1; e.busy = 1;
                exp_q.push_back(e);
                rr = 1;
            end else begin
                int last;
                last = (k == 0) ? TMO : k;
                e.rd_en = 1; e.busy = 1;
                for (int j = 1; j <= last; j++) exp_q.push_back(e);
                e.rd_en = 0; e.resp = 1; e.tmo = (k == 0);
                e.rdata = (k == 0) ? ERR : rdat;
                exp_q.push_back(e);
                rr = last + 1;
            end
        end
        for (int j = 1; j <= rr; j++) begin
            @(negedge clk);
            if (rst3 && j == 3) begin
                n_rst = 0; m_drv = 0; i_rd_valid = 0;
                exp_q.delete();
                m_off = '0; m_wdata = '0;
                #1;
                chk("rst_rd_en", o_rd_en, 1'b0);
                chk("rst_busy", o_busy, 1'b0);
                chk("rst_address", o_address, 8'h00);
                chk("rst_wr_data", o_wr_data, 32'h0);
                chk("rst_bus_released", bus_control[0] === 1'b1, 1'b0);
                @(negedge clk);
                @(negedge clk);
                n_rst = 1;
                return;
            end
            if (rnw && hit && j <= rr - 1) begin
                i_rd_valid = (j == k);
                i_rd_data  = (j == k) ? rdat : $urandom;
            end else begin
                i_rd_valid = 1'($urandom_range(0, 1));
                i_rd_data  = $urandom;
            end
            if (rnw && hit && j <= rr - 2 && $urandom_range(0, 1) == 1) begin
                m_addr = BASE + $urandom_range(0, SPAN - 1); m_data = $urandom;
                m_ctrl = {1'($urandom_range(0, 1)), 1'b1}; m_drv = 1;
            end else begin
                m_drv = 0;
            end
        end
        @(negedge clk);
        m_drv = 0; i_rd_valid = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int n, n2, cnt, r, k;
        logic [31:0] rd;
        cyc = 0; n_cmp = 0; n_bad = 0;
        m_off = '0; m_wdata = '0;
        m_drv = 0; m_addr = '0; m_data = '0; m_ctrl = '0;
        i_rd_valid = 0; i_rd_data = '0;
        n_rst = 1;
        #1 n_rst = 0;
        #1;
        chk("reset_busy", o_busy, 1'b0);
        chk("reset_wr_en", o_wr_en, 1'b0);
        chk("reset_rd_en", o_rd_en, 1'b0);
        chk("reset_timeout", o_timeout, 1'b0);
        chk("reset_address", o_address, 8'h00);
        chk("reset_wr_data", o_wr_data, 32'h0);
        repeat (3) @(negedge clk);
        n_rst = 1;

        // Write hit
        do_txn(32'h1004, 32'hA5A5_0001, 0, 0, 32'h0, 0, n);
        chk("wr_strobe", log_wr_en[n+1], 1'b1);
        chk("wr_strobe_end", log_wr_en[n+2], 1'b0);
        chk("wr_address", log_addr[n+1], 8'h04);
        chk("wr_data", log_wdata[n+1], 32'hA5A5_0001);
        chk("wr_idle", log_busy[n+2], 1'b0);

        // Read, zero wait
        do_txn(32'h10FC, $urandom, 1, 1, 32'h1234_5678, 0, n);
        chk("rd0_ctrl", log_ctrl[n+2], 2'b11);
        chk("rd0_data", log_bdata[n+2], 32'h1234_5678);
        chk("rd0_addr", log_baddr[n+2], 32'h0000_10FC);
        chk("rd0_rd_en_drop", log_rd_en[n+2], 1'b0);
        chk("rd0_released", log_ctrl[n+3][0] === 1'b1, 1'b0);

        // Read, five wait cycles
        rd = $urandom;
        do_txn(BASE + $urandom_range(0, SPAN - 1), $urandom, 1, 5, rd, 0, n);
        cnt = 0;
        for (int i = 1; i <= 7; i++) cnt += int'(log_rd_en[n+i]);
        chk("rd5_rd_en_cycles", cnt, 5);
        chk("rd5_ctrl", log_ctrl[n+6], 2'b11);
        chk("rd5_data", log_bdata[n+6], rd);
        cnt = 0;
        for (int i = 1; i <= 7; i++) cnt += int'(log_tmo[n+i]);
        chk("rd5_no_timeout", cnt, 0);

        // Timeout, then a late response that must be ignored
        do_txn(32'h1040, $urandom, 1, 0, 32'h0, 0, n);
        chk("tmo_data", log_bdata[n+17], 32'hDEAD_BEEF);
        chk("tmo_pulse", log_tmo[n+17], 1'b1);
        chk("tmo_ctrl", log_ctrl[n+17], 2'b11);
        chk("tmo_rd_en_last", log_rd_en[n+16], 1'b1);
        chk("tmo_rd_en_drop", log_rd_en[n+17], 1'b0);
        chk("tmo_pulse_end", log_tmo[n+18], 1'b0);
        @(negedge clk);
        @(negedge clk);
        i_rd_valid = 1; i_rd_data = $urandom;
        @(negedge clk);
        i_rd_valid = 0;
        @(negedge clk);
        chk("late_valid_busy", log_busy[n+21], 1'b0);
        chk("late_valid_ctrl", log_ctrl[n+21][0] === 1'b1, 1'b0);

        // Misses
        for (int a = 0; a < 2; a++) begin
            for (int w = 0; w < 2; w++) begin
                do_txn((a == 0) ? 32'h2000 : 32'h0FFF, $urandom, w[0], 1, 32'h0, 0, n);
                chk("miss_busy", log_busy[n+1], 1'b0);
                chk("miss_wr_en", log_wr_en[n+1], 1'b0);
                chk("miss_rd_en", log_rd_en[n+1], 1'b0);
            end
        end

        // Reset in the middle of a read, then a normal read
        do_txn(32'h1080, $urandom, 1, 0, 32'h0, 1, n);
        do_txn(32'h1084, $urandom, 1, 2, 32'hCAFE_F00D, 0, n2);
        chk("post_rst_ctrl", log_ctrl[n2+3], 2'b11);
        chk("post_rst_data", log_bdata[n2+3], 32'hCAFE_F00D);
        chk("post_rst_addr", log_baddr[n2+3], 32'h0000_1084);

        // Randomized traffic
        for (int t = 0; t < 120; t++) begin
            r = $urandom_range(0, 9);
            if (r <= 1) begin
                do_txn(miss_addr(), $urandom, 1'($urandom_range(0, 1)), 1, 32'h0, 0, n);
            end else if (r <= 4) begin
                do_txn(BASE + $urandom_range(0, SPAN - 1), $urandom, 0, 0, 32'h0, 0, n);
            end else if (r <= 8) begin
                k = $urandom_range(0, TMO);
                do_txn(BASE + $urandom_range(0, SPAN - 1), $urandom, 1, k, $urandom, 0, n);
            end else begin
                k = $urandom_range(3, TMO);
                do_txn(BASE + $urandom_range(0, SPAN - 1), $urandom, 1, k, $urandom, 1, n);
            end
            idle($urandom_range(0, 3));
        end
        @(negedge clk);
        m_drv = 0; i_rd_valid = 0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
